// File: rtl/vx_sau_pkg.sv
// Shared definitions for the systolic-array unit: drain FSM states, index sizing,
// signed saturation helper and the flattened-matrix bus offset macro.
`ifndef VX_SAU_PKG_SV
`define VX_SAU_PKG_SV

// Bit offset of element (r,c) inside an N x N bus of W-bit elements.
`define VX_SAU_ELEM_OFS(r, c, n, w) ((((r) * (n)) + (c)) * (w))

package vx_sau_pkg;

    localparam int MAX_MATRIX_SIZE = 16;
    localparam int SAT_WIDTH       = 64;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    typedef enum logic [1:0] {
        DRAIN_IDLE   = 2'd0,
        DRAIN_CLEAR  = 2'd1,
        DRAIN_STREAM = 2'd2
    } drain_state_e;

    typedef logic [$clog2(MAX_MATRIX_SIZE)-1:0] elem_idx_t;

    // Clamp a signed value to the range of an out_w-bit two's complement number.
    function automatic logic signed [SAT_WIDTH-1:0] sat_narrow(
        input logic signed [SAT_WIDTH-1:0] val,
        input int                          out_w
    );
        logic signed [SAT_WIDTH-1:0] max_v;
        logic signed [SAT_WIDTH-1:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -max_v - 64'sd1;
        if (out_w >= SAT_WIDTH) begin
            return val;
        end
        if (val > max_v) begin
            return max_v;
        end
        if (val < min_v) begin
            return min_v;
        end
        return val;
    endfunction

endpackage

`endif

// File: rtl/vx_sau_sat.sv
// Combinational signed saturating narrower from ACC_WIDTH down to OUT_WIDTH bits.
module vx_sau_sat
    import vx_sau_pkg::*;
#(
    parameter int ACC_WIDTH = 32,
    parameter int OUT_WIDTH = 32
) (
    input  logic [ACC_WIDTH-1:0] acc_in,
    output logic [OUT_WIDTH-1:0] sat_out
);

    generate
        if (OUT_WIDTH == ACC_WIDTH) begin : g_pass
            assign sat_out = acc_in;
        end else begin : g_sat
            logic signed [SAT_WIDTH-1:0] wide;
            logic signed [SAT_WIDTH-1:0] narrowed;
            logic                        unused_hi;

            assign wide      = SAT_WIDTH'(signed'(acc_in));
            assign narrowed  = sat_narrow(wide, OUT_WIDTH);
            assign sat_out   = narrowed[OUT_WIDTH-1:0];
            // Upper bits are only a sign extension of the kept result.
            assign unused_hi = ^narrowed[SAT_WIDTH-1:OUT_WIDTH];
        end
    endgenerate

endmodule

// File: rtl/vx_sau_drain.sv
// Result drain: captures the N x N accumulator matrix, pulses acc_clear, then streams
// saturated elements one per beat in row- or column-major order.
module vx_sau_drain
    import vx_sau_pkg::*;
#(
    parameter int CORE_ID     = 0,
    parameter int MATRIX_SIZE = 3,
    parameter int ACC_WIDTH   = 32,
    parameter int OUT_WIDTH   = 32,
    localparam int IDX_W      = idx_w(MATRIX_SIZE)
) (
    input  logic                                         clk,
    input  logic                                         reset,
    input  logic                                         res_valid,
    output logic                                         res_ready,
    input  logic [MATRIX_SIZE*MATRIX_SIZE*ACC_WIDTH-1:0] res_data,
    input  logic                                         res_transpose,
    output logic                                         acc_clear,
    output logic                                         out_valid,
    input  logic                                         out_ready,
    output logic [OUT_WIDTH-1:0]                         out_data,
    output logic [IDX_W-1:0]                             out_row,
    output logic [IDX_W-1:0]                             out_col,
    output logic                                         out_last,
    output logic                                         busy
);

    localparam int             N              = MATRIX_SIZE;
    localparam int             ELEMS          = N * N;
    localparam logic [IDX_W-1:0] LAST_IDX     = IDX_W'(N - 1);
    localparam int             unused_core_id = CORE_ID;

    drain_state_e               state_q;
    logic [ELEMS*ACC_WIDTH-1:0] mat_q;
    logic                       transpose_q;
    logic [IDX_W-1:0]           row_q;
    logic [IDX_W-1:0]           col_q;
    logic [IDX_W-1:0]           row_nx;
    logic [IDX_W-1:0]           col_nx;
    logic                       capture;
    logic [ACC_WIDTH-1:0]       elem_sel;
    logic [OUT_WIDTH-1:0]       elem_sat;

    assign capture = (state_q == DRAIN_IDLE) && res_valid && res_ready;
    assign out_row = row_q;
    assign out_col = col_q;

    // Transposed streaming walks rows fastest; normal streaming walks columns fastest.
    always_comb begin
        row_nx = row_q;
        col_nx = col_q;
        if (transpose_q) begin
            if (row_q == LAST_IDX) begin
                row_nx = '0;
                col_nx = col_q + 1'b1;
            end else begin
                row_nx = row_q + 1'b1;
            end
        end else begin
            if (col_q == LAST_IDX) begin
                col_nx = '0;
                row_nx = row_q + 1'b1;
            end else begin
                col_nx = col_q + 1'b1;
            end
        end
    end

    // The first beat comes straight off the input bus since the buffer loads on the same edge.
    always_comb begin
        elem_sel = mat_q[`VX_SAU_ELEM_OFS(int'(row_nx), int'(col_nx), N, ACC_WIDTH) +: ACC_WIDTH];
        if (capture) begin
            elem_sel = res_data[ACC_WIDTH-1:0];
        end
    end

    vx_sau_sat #(
        .ACC_WIDTH (ACC_WIDTH),
        .OUT_WIDTH (OUT_WIDTH)
    ) u_sat (
        .acc_in  (elem_sel),
        .sat_out (elem_sat)
    );

    // Matrix buffer contents are meaningless until a capture, so it carries no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            mat_q       <= res_data;
            transpose_q <= res_transpose;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= DRAIN_IDLE;
            res_ready <= 1'b1;
            acc_clear <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            row_q     <= '0;
            col_q     <= '0;
        end else begin
            acc_clear <= 1'b0;
            unique case (state_q)
                DRAIN_IDLE: begin
                    if (capture) begin
                        state_q   <= DRAIN_CLEAR;
                        acc_clear <= 1'b1;
                        res_ready <= 1'b0;
                        busy      <= 1'b1;
                        out_valid <= 1'b1;
                        out_data  <= elem_sat;
                        row_q     <= '0;
                        col_q     <= '0;
                        out_last  <= (N == 1);
                    end
                end
                DRAIN_CLEAR, DRAIN_STREAM: begin
                    if (out_ready && out_last) begin
                        state_q   <= DRAIN_IDLE;
                        res_ready <= 1'b1;
                        busy      <= 1'b0;
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                    end else if (out_ready) begin
                        state_q  <= DRAIN_STREAM;
                        row_q    <= row_nx;
                        col_q    <= col_nx;
                        out_data <= elem_sat;
                        out_last <= (row_nx == LAST_IDX) && (col_nx == LAST_IDX);
                    end else begin
                        state_q <= DRAIN_STREAM;
                    end
                end
                default: begin
                    state_q <= DRAIN_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vx_sau_drain.sv
// Scoreboard bench for vx_sau_drain: 3x3 instance with 16-bit outputs plus a 1x1 corner instance.
module tb_vx_sau_drain;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        res_valid = 1'b0;
    logic        res_ready;
    logic [287:0] res_data = '0;
    logic        res_transpose = 1'b0;
    logic        acc_clear;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] out_data;
    logic [1:0]  out_row;
    logic [1:0]  out_col;
    logic        out_last;
    logic        busy;

    logic        res_valid1 = 1'b0;
    logic        res_ready1;
    logic [31:0] res_data1 = '0;
    logic        res_transpose1 = 1'b0;
    logic        acc_clear1;
    logic        out_valid1;
    logic        out_ready1 = 1'b1;
    logic [15:0] out_data1;
    logic [0:0]  out_row1;
    logic [0:0]  out_col1;
    logic        out_last1;
    logic        busy1;

    typedef struct {
        logic [15:0] data;
        logic [1:0]  row;
        logic [1:0]  col;
        logic        last;
    } beat_t;

    beat_t exp_q[$];
    beat_t exp1_q[$];
    int    checks = 0;
    int    errors = 0;

    logic        stall_pending = 1'b0;
    logic [15:0] held_data;
    logic [1:0]  held_row;
    logic [1:0]  held_col;
    logic        held_last;

    int basic_mat[9] = '{0, 1, 2, 10, 11, 12, 20, 21, 22};
    int basic_col[9] = '{0, 10, 20, 1, 11, 21, 2, 12, 22};
    int sat_mat[9]   = '{40000, -40000, 32767, -32768, 32'h0001_0005, 32768, -32769, -1, 0};
    int sat_exp[9]   = '{32767, -32768, 32767, -32768, 32767, 32767, -32768, -1, 0};

    vx_sau_drain #(
        .CORE_ID     (0),
        .MATRIX_SIZE (3),
        .ACC_WIDTH   (32),
        .OUT_WIDTH   (16)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_transpose (res_transpose),
        .acc_clear     (acc_clear),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
        .out_row       (out_row),
        .out_col       (out_col),
        .out_last      (out_last),
        .busy          (busy)
    );

    vx_sau_drain #(
        .CORE_ID     (1),
        .MATRIX_SIZE (1),
        .ACC_WIDTH   (32),
        .OUT_WIDTH   (16)
    ) dut1 (
        .clk           (clk),
        .reset         (reset),
        .res_valid     (res_valid1),
        .res_ready     (res_ready1),
        .res_data      (res_data1),
        .res_transpose (res_transpose1),
        .acc_clear     (acc_clear1),
        .out_valid     (out_valid1),
        .out_ready     (out_ready1),
        .out_data      (out_data1),
        .out_row       (out_row1),
        .out_col       (out_col1),
        .out_last      (out_last1),
        .busy          (busy1)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic set_matrix(input int v[9]);
        for (int r = 0; r < 3; r++) begin
            for (int c = 0; c < 3; c++) begin
                res_data[(r*3+c)*32 +: 32] = v[r*3+c];
            end
        end
    endtask

    task automatic push_expected(input int v[9], input bit tr);
        beat_t b;
        for (int i = 0; i < 9; i++) begin
            b.data = 16'(v[i]);
            b.row  = tr ? 2'(i % 3) : 2'(i / 3);
            b.col  = tr ? 2'(i / 3) : 2'(i % 3);
            b.last = (i == 8);
            exp_q.push_back(b);
        end
    endtask

    // Presents a matrix and returns #1 into the cycle after the capture edge.
    task automatic apply_stimulus(input bit tr);
        int k = 0;
        res_transpose = tr;
        res_valid     = 1'b1;
        while (!res_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!res_ready) begin
            checks++;
            errors++;
            $display("[TB] FAIL capture_wait: got res_ready=0 expected 1 within 50 cycles");
        end
        @(posedge clk);
        #1;
        res_valid = 1'b0;
        check_output("acc_clear_pulse", acc_clear, 1);
        check_output("first_beat_valid", out_valid, 1);
        check_output("busy_after_capture", busy, 1);
        check_output("ready_low_after_capture", res_ready, 0);
    endtask

    task automatic drain(input bit bp, output int cycles);
        int k = 0;
        while (exp_q.size() != 0 && k < 100) begin
            out_ready = bp ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
            @(negedge clk);
            #1;
            @(posedge clk);
            #1;
            if (k == 0) begin
                check_output("acc_clear_single_cycle", acc_clear, 0);
            end
            k++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
        end
        out_ready = 1'b1;
        cycles    = k;
    endtask

    always @(negedge clk) begin
        if (reset && out_valid) begin
            check_output("ready_low_while_streaming", res_ready, 0);
            if (stall_pending) begin
                check_output("stall_stable", {out_data, out_row, out_col, out_last},
                             {held_data, held_row, held_col, held_last});
            end
            if (out_ready) begin
                stall_pending = 1'b0;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL unexpected_beat: got data %0h expected no beat", out_data);
                end else begin
                    beat_t b;
                    b = exp_q.pop_front();
                    check_output("beat_data", out_data, b.data);
                    check_output("beat_index", {out_row, out_col}, {b.row, b.col});
                    check_output("beat_last", out_last, b.last);
                end
            end else begin
                stall_pending = 1'b1;
                held_data     = out_data;
                held_row      = out_row;
                held_col      = out_col;
                held_last     = out_last;
            end
        end else begin
            stall_pending = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (reset && out_valid1 && out_ready1) begin
            if (exp1_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL n1_unexpected_beat: got data %0h expected no beat", out_data1);
            end else begin
                beat_t b;
                b = exp1_q.pop_front();
                check_output("n1_beat_data", out_data1, b.data);
                check_output("n1_beat_index", {out_row1, out_col1}, 2'b00);
                check_output("n1_beat_last", out_last1, b.last);
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no finish expected finish before 100000");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int cyc;
        beat_t b1;

        #1 reset = 1'b0;
        #2;
        check_output("reset_res_ready", res_ready, 1);
        check_output("reset_out_valid", out_valid, 0);
        check_output("reset_acc_clear", acc_clear, 0);
        check_output("reset_busy", busy, 0);
        check_output("reset_outputs", {out_data, out_row, out_col, out_last}, 0);
        #9 reset = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] basic row-major drain");
        set_matrix(basic_mat);
        push_expected(basic_mat, 1'b0);
        apply_stimulus(1'b0);
        drain(1'b0, cyc);
        check_output("basic_drain_cycles", cyc, 9);
        check_output("basic_ready_after_last", res_ready, 1);
        check_output("basic_idle_valid", out_valid, 0);
        check_output("basic_idle_busy", busy, 0);

        $display("[TB] transposed drain");
        push_expected(basic_col, 1'b1);
        apply_stimulus(1'b1);
        drain(1'b0, cyc);
        check_output("transpose_drain_cycles", cyc, 9);

        $display("[TB] backpressure drain");
        push_expected(basic_mat, 1'b0);
        apply_stimulus(1'b0);
        drain(1'b1, cyc);
        check_output("bp_ready_after_last", res_ready, 1);

        $display("[TB] reset mid-stream");
        push_expected(basic_mat, 1'b0);
        apply_stimulus(1'b0);
        cyc = 0;
        while (exp_q.size() > 5 && cyc < 50) begin
            @(negedge clk);
            #1;
            cyc++;
        end
        check_output("beats_before_reset", exp_q.size(), 5);
        reset = 1'b0;
        #1;
        check_output("midreset_out_valid", out_valid, 0);
        check_output("midreset_res_ready", res_ready, 1);
        check_output("midreset_acc_clear", acc_clear, 0);
        check_output("midreset_busy", busy, 0);
        check_output("midreset_outputs", {out_data, out_row, out_col, out_last}, 0);
        exp_q.delete();
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_output("post_reset_ready", res_ready, 1);
        check_output("post_reset_valid", out_valid, 0);
        #1;

        $display("[TB] saturation drain after reset");
        set_matrix(sat_mat);
        push_expected(sat_exp, 1'b0);
        apply_stimulus(1'b0);
        drain(1'b0, cyc);
        check_output("sat_drain_cycles", cyc, 9);

        $display("[TB] single-element corner");
        b1.data = 16'd7;
        b1.row  = 2'd0;
        b1.col  = 2'd0;
        b1.last = 1'b1;
        exp1_q.push_back(b1);
        res_data1  = 32'd7;
        out_ready1 = 1'b1;
        check_output("n1_ready_idle", res_ready1, 1);
        res_valid1 = 1'b1;
        @(posedge clk);
        #1;
        res_valid1 = 1'b0;
        check_output("n1_acc_clear", acc_clear1, 1);
        check_output("n1_valid", out_valid1, 1);
        check_output("n1_busy", busy1, 1);
        @(posedge clk);
        #1;
        check_output("n1_idle_valid", out_valid1, 0);
        check_output("n1_idle_ready", res_ready1, 1);
        check_output("n1_idle_busy", busy1, 0);
        check_output("n1_acc_clear_drop", acc_clear1, 0);
        check_output("n1_queue_empty", exp1_q.size(), 0);

        repeat (3) @(posedge clk);
        #1;
        check_output("final_queue_empty", exp_q.size(), 0);
        check_output("final_no_clear", acc_clear, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
